prog_run_ctl: RTL and testbench
===============================

Name: prog_run_ctl

Overview:
- Parametrised run-control and instrumentation unit for the processor top level.
- Owns the Start/Ack program handshake, program selection (multiple programs resident in instruction ROM), PC load, core run-enable, halt detection and performance counters.
- Generalises the old fixed 16-bit cycle counter and all-ones halt flag: adds per-program start addresses, stall-aware instruction counting, jump counting, saturation and abort/restart.

Parameters:
- PC_W, 10, program counter width.
- INST_W, 9, instruction width; halt opcode is all ones of INST_W.
- CNT_W, 16, width of each performance counter.
- NUM_PROG, 3, number of selectable programs (>=1).
- SEL_W, 2, ProgSel width; must satisfy 2**SEL_W >= NUM_PROG.
- PROG_BASE, {10'd0,10'd128,10'd256} (packed NUM_PROG*PC_W, entry 0 in LSBs), start PC per program.
- WDOG_LIMIT, 16'hFFF0, watchdog cycle limit (used only with the optional feature).

Ports:
- Clk  in  1  clock, posedge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  level; high = hold/load selected program, falling edge launches it.
- ProgSel  in  SEL_W  program index, sampled each LOAD cycle.
- Instruction  in  INST_W  current instruction from instruction ROM.
- StallIn  in  1  core stall; no instruction retires this cycle.
- JumpTaken  in  1  core took a branch/jump this cycle.
- PcLoad  out  1  force PC to PcLoadVal.
- PcLoadVal  out  PC_W  start address of the selected program.
- CoreRun  out  1  PC may advance and state may update.
- Ack  out  1  program finished.
- CycleCt  out  CNT_W  RUN cycles, including stall cycles and the halt cycle.
- InstCt  out  CNT_W  retired non-halt instructions.
- JumpCt  out  CNT_W  taken jumps.
- CntOvf  out  1  sticky; any counter saturated.
- Timeout  out  1  watchdog fired (forced 0 without the optional feature).

Behaviour:
- States: IDLE, LOAD, RUN, DONE.
- Reset (synchronous, overrides all): state IDLE; all counters 0; CntOvf, Ack, Timeout, PcLoad, CoreRun = 0; PcLoadVal = PROG_BASE[0].
- IDLE: Start=1 -> LOAD at next edge.
- LOAD: PcLoad=1, CoreRun=0.
  - PcLoadVal = PROG_BASE[ProgSel] (combinational from current ProgSel).
  - ProgSel >= NUM_PROG selects entry 0.
  - Counters, CntOvf and Timeout are cleared every LOAD cycle.
  - Stays in LOAD while Start=1; Start=0 -> RUN. The PC was loaded on the last LOAD cycle.
- RUN: CoreRun=1, PcLoad=0.
  - CycleCt increments every cycle.
  - InstCt increments when StallIn=0 and Instruction != all-ones.
  - JumpCt increments when JumpTaken=1 and StallIn=0.
- Halt: Instruction == all-ones with StallIn=0 in RUN -> DONE next edge. That cycle counts in CycleCt but not InstCt.
- DONE: Ack=1, CoreRun=0, counters frozen. Start=1 -> LOAD; Ack drops in the same edge.
- Start=1 during RUN: abort, go to LOAD next edge; counters cleared in LOAD.
- Saturation: a counter at all-ones holds and sets CntOvf (sticky until LOAD or Reset).
- Simultaneous halt and Start in RUN: Start wins (LOAD).
- All outputs are registered or decoded from state; no combinational path from Start to CoreRun.

Optional Feature:
- Macro: PROG_RUN_WATCHDOG_EN.
- Defined: in RUN, when CycleCt reaches WDOG_LIMIT the block goes to DONE next edge with Timeout=1 and Ack=1. Timeout is cleared in LOAD/Reset. Halt and watchdog in the same cycle: DONE with Timeout=1.
- Undefined: no comparator is built, Timeout is tied to 0, and WDOG_LIMIT is ignored.

Decomposition:
- Shared package proc_pkg holds:
  - typedef enum logic[1:0] run_state_t {IDLE, LOAD, RUN, DONE}
  - function is_halt(inst) (all-ones test)
  - default CNT_W/PC_W localparams
- One sub-module: sat_counter (parameter W; inputs Clk, Reset, Clr, Inc; outputs Q, Sat). Instantiated three times.

Test Plan:
- Reset mid-RUN: Reset=1 for one cycle -> next cycle state IDLE, CycleCt=0, Ack=0, CoreRun=0.
- Program select: ProgSel=2, Start 1 for 3 cycles then 0 -> PcLoad=1 with PcLoadVal=256 during LOAD; CoreRun=1 next cycle. ProgSel=3 gives PcLoadVal=0.
- Normal run: 5 non-halt instructions (1 stalled cycle, 2 JumpTaken with one stalled), then halt -> CycleCt=7, InstCt=4, JumpCt=1, Ack=1 the cycle after halt.
- Abort: Start=1 at RUN cycle 4 -> LOAD next edge, counters 0, Ack stays 0; release -> fresh RUN.
- Saturation: CNT_W=4, 20 RUN cycles -> CycleCt=15 holding, CntOvf=1 until next LOAD.
- Watchdog (PROG_RUN_WATCHDOG_EN, WDOG_LIMIT=10, no halt) -> DONE after CycleCt=10, Timeout=1, Ack=1. Without the macro, same stimulus stays in RUN with Timeout=0.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared types and helpers for the processor run-control slice.
package proc_pkg;

  localparam int DEF_PC_W  = 10;
  localparam int DEF_CNT_W = 16;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} run_state_t;

  // The halt opcode is all ones of the instruction width; callers zero-extend into 64 bits.
  function automatic logic is_halt(input logic [63:0] inst, input int unsigned w);
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    return &(inst | ~mask);
  endfunction

endpackage

// File: rtl/prog_run_ctl_sat_counter.sv
// Saturating up-counter with synchronous clear and a sticky saturation flag.
module sat_counter
  import proc_pkg::*;
#(
  parameter int W = DEF_CNT_W
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Clr,
  input  logic         Inc,
  output logic [W-1:0] Q,
  output logic         Sat
);

  // Sat flags an increment lost at all-ones, so it stays set until the next clear.
  always_ff @(posedge Clk) begin
    if (Reset || Clr) begin
      Q   <= '0;
      Sat <= 1'b0;
    end else if (Inc) begin
      if (&Q) begin
        Sat <= 1'b1;
      end else begin
        Q <= Q + W'(1);
      end
    end
  end

endmodule

// File: rtl/prog_run_ctl.sv
// Program run control: Start/Ack handshake, program select, halt detect, perf counters.
// Optional watchdog enabled by defining PROG_RUN_WATCHDOG_EN.
module prog_run_ctl
  import proc_pkg::*;
#(
  parameter int                         PC_W       = DEF_PC_W,
  parameter int                         INST_W     = 9,
  parameter int                         CNT_W      = DEF_CNT_W,
  parameter int                         NUM_PROG   = 3,
  parameter int                         SEL_W      = 2,
  parameter logic [NUM_PROG*PC_W-1:0]   PROG_BASE  = {PC_W'(256), PC_W'(128), PC_W'(0)},
  parameter int unsigned                WDOG_LIMIT = 32'hFFF0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [SEL_W-1:0]  ProgSel,
  input  logic [INST_W-1:0] Instruction,
  input  logic              StallIn,
  input  logic              JumpTaken,
  output logic              PcLoad,
  output logic [PC_W-1:0]   PcLoadVal,
  output logic              CoreRun,
  output logic              Ack,
  output logic [CNT_W-1:0]  CycleCt,
  output logic [CNT_W-1:0]  InstCt,
  output logic [CNT_W-1:0]  JumpCt,
  output logic              CntOvf,
  output logic              Timeout
);

  run_state_t state;
  logic       haltInst;
  logic       retire;
  logic       clr;
  logic       incCyc;
  logic       incInst;
  logic       incJump;
  logic       satCyc;
  logic       satInst;
  logic       satJump;
  logic       wdogHit;

  // Out-of-range selections fall back to program 0.
  function automatic logic [PC_W-1:0] baseOf(input logic [SEL_W-1:0] sel);
    int idx;
    idx = (int'(sel) < NUM_PROG) ? int'(sel) : 0;
    return PROG_BASE[idx*PC_W +: PC_W];
  endfunction

  assign haltInst = is_halt(64'(Instruction), INST_W);
  assign retire   = (state == RUN) && !StallIn;

  // Start forces LOAD from every state, so clearing on Start zeroes the counters on LOAD entry.
  assign clr     = Start || (state == LOAD);
  assign incCyc  = (state == RUN);
  assign incInst = retire && !haltInst;
  assign incJump = retire && JumpTaken;

`ifdef PROG_RUN_WATCHDOG_EN
  logic timeoutQ;

  // Fire one cycle early so CycleCt lands exactly on the limit as DONE is entered.
  assign wdogHit = (state == RUN) && (CycleCt == CNT_W'(WDOG_LIMIT - 1));

  always_ff @(posedge Clk) begin
    if (Reset || clr) begin
      timeoutQ <= 1'b0;
    end else if (wdogHit) begin
      timeoutQ <= 1'b1;
    end
  end

  assign Timeout = timeoutQ;
`else
  logic unusedWdogLimit;

  assign unusedWdogLimit = (WDOG_LIMIT != 0);
  assign wdogHit         = 1'b0;
  assign Timeout         = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (Start) state <= LOAD;
        LOAD: if (!Start) state <= RUN;
        RUN: begin
          if (Start) begin
            state <= LOAD;
          end else if (wdogHit || (haltInst && !StallIn)) begin
            state <= DONE;
          end
        end
        DONE: if (Start) state <= LOAD;
        default: state <= IDLE;
      endcase
    end
  end

  assign PcLoad    = (state == LOAD);
  assign CoreRun   = (state == RUN);
  assign Ack       = (state == DONE);
  assign PcLoadVal = (state == LOAD) ? baseOf(ProgSel) : PROG_BASE[PC_W-1:0];
  assign CntOvf    = satCyc || satInst || satJump;

  sat_counter #(.W(CNT_W)) uCycCt (
    .Clk   (Clk),
    .Reset (Reset),
    .Clr   (clr),
    .Inc   (incCyc),
    .Q     (CycleCt),
    .Sat   (satCyc)
  );

  sat_counter #(.W(CNT_W)) uInstCt (
    .Clk   (Clk),
    .Reset (Reset),
    .Clr   (clr),
    .Inc   (incInst),
    .Q     (InstCt),
    .Sat   (satInst)
  );

  sat_counter #(.W(CNT_W)) uJumpCt (
    .Clk   (Clk),
    .Reset (Reset),
    .Clr   (clr),
    .Inc   (incJump),
    .Q     (JumpCt),
    .Sat   (satJump)
  );

endmodule

// File: tb/tb_prog_run_ctl.sv
// Scoreboard bench for prog_run_ctl (4-bit counters, watchdog limit 10).
module tb_prog_run_ctl;

  localparam int PC_W   = 10;
  localparam int INST_W = 9;
  localparam int CNT_W  = 4;
  localparam int SEL_W  = 2;

  logic              Clk         = 1'b0;
  logic              Reset       = 1'b1;
  logic              Start       = 1'b0;
  logic [SEL_W-1:0]  ProgSel     = '0;
  logic [INST_W-1:0] Instruction = '0;
  logic              StallIn     = 1'b0;
  logic              JumpTaken   = 1'b0;
  logic              PcLoad;
  logic [PC_W-1:0]   PcLoadVal;
  logic              CoreRun;
  logic              Ack;
  logic [CNT_W-1:0]  CycleCt;
  logic [CNT_W-1:0]  InstCt;
  logic [CNT_W-1:0]  JumpCt;
  logic              CntOvf;
  logic              Timeout;

  prog_run_ctl #(
    .PC_W       (PC_W),
    .INST_W     (INST_W),
    .CNT_W      (CNT_W),
    .NUM_PROG   (3),
    .SEL_W      (SEL_W),
    .WDOG_LIMIT (10)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Start       (Start),
    .ProgSel     (ProgSel),
    .Instruction (Instruction),
    .StallIn     (StallIn),
    .JumpTaken   (JumpTaken),
    .PcLoad      (PcLoad),
    .PcLoadVal   (PcLoadVal),
    .CoreRun     (CoreRun),
    .Ack         (Ack),
    .CycleCt     (CycleCt),
    .InstCt      (InstCt),
    .JumpCt      (JumpCt),
    .CntOvf      (CntOvf),
    .Timeout     (Timeout)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    int          at;
    string       nm;
    logic [26:0] v;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  function automatic string fmt(input logic [26:0] v);
    return $sformatf("pcl=%0b pcv=%0d run=%0b ack=%0b cyc=%0d inst=%0d jmp=%0d ovf=%0b tmo=%0b",
                     v[26], v[25:16], v[15], v[14], v[13:10], v[9:6], v[5:2], v[1], v[0]);
  endfunction

  // Monitor: every negedge, consume all expectations due at or before this cycle.
  exp_t        mon;
  logic [26:0] act;
  always @(negedge Clk) begin
    act = {PcLoad, PcLoadVal, CoreRun, Ack, CycleCt, InstCt, JumpCt, CntOvf, Timeout};
    while (sbq.size() > 0 && sbq[0].at <= cyc) begin
      mon = sbq.pop_front();
      total++;
      if (mon.at < cyc) begin
        bad++;
        $display("FAIL %s: expectation for cycle %0d never sampled (now %0d)", mon.nm, mon.at, cyc);
      end else if (act !== mon.v) begin
        bad++;
        $display("FAIL %s @%0d: got %s ; want %s", mon.nm, cyc, fmt(act), fmt(mon.v));
      end
    end
  end

  task automatic drv(input logic rst, input logic st, input logic [SEL_W-1:0] sel,
                     input logic hlt, input logic stl, input logic jmp);
    @(posedge Clk);
    #1;
    Reset       = rst;
    Start       = st;
    ProgSel     = sel;
    Instruction = hlt ? '1 : 9'h0A5;
    StallIn     = stl;
    JumpTaken   = jmp;
  endtask

  task automatic ex(input string nm, input logic pcl, input logic [PC_W-1:0] pcv,
                    input logic run, input logic ack, input int c, input int i, input int j,
                    input logic ovf, input logic tmo);
    exp_t e;
    e.at = cyc;
    e.nm = nm;
    e.v  = {pcl, pcv, run, ack, 4'(c), 4'(i), 4'(j), ovf, tmo};
    sbq.push_back(e);
  endtask

  initial begin
    // Reset, then select program 2 with Start held for three cycles.
    drv(1, 0, 2'd0, 0, 0, 0); ex("reset",     0, 0,   0, 0, 0, 0, 0, 0, 0);
    drv(0, 1, 2'd2, 0, 0, 0); ex("idle",      0, 0,   0, 0, 0, 0, 0, 0, 0);
    drv(0, 1, 2'd2, 0, 0, 0); ex("load1",     1, 256, 0, 0, 0, 0, 0, 0, 0);
    drv(0, 1, 2'd2, 0, 0, 0); ex("load2",     1, 256, 0, 0, 0, 0, 0, 0, 0);
    drv(0, 0, 2'd2, 0, 0, 1); ex("load3",     1, 256, 0, 0, 0, 0, 0, 0, 0);
    // Normal run: jump, stalled jump, three plain, stalled halt, halt.
    drv(0, 0, 2'd2, 0, 0, 1); ex("run_start", 0, 0,   1, 0, 0, 0, 0, 0, 0);
    drv(0, 0, 2'd2, 0, 1, 1); ex("run_c1",    0, 0,   1, 0, 1, 1, 1, 0, 0);
    drv(0, 0, 2'd2, 0, 0, 0); ex("run_c2",    0, 0,   1, 0, 2, 1, 1, 0, 0);
    drv(0, 0, 2'd2, 0, 0, 0); ex("run_c3",    0, 0,   1, 0, 3, 2, 1, 0, 0);
    drv(0, 0, 2'd2, 0, 0, 0); ex("run_c4",    0, 0,   1, 0, 4, 3, 1, 0, 0);
    drv(0, 0, 2'd2, 1, 1, 0); ex("run_c5",    0, 0,   1, 0, 5, 4, 1, 0, 0);
    drv(0, 0, 2'd2, 1, 0, 0); ex("stall_hlt", 0, 0,   1, 0, 6, 4, 1, 0, 0);
    drv(0, 0, 2'd2, 0, 0, 1); ex("done",      0, 0,   0, 1, 7, 4, 1, 0, 0);
    drv(0, 0, 2'd2, 0, 0, 0); ex("done_hold", 0, 0,   0, 1, 7, 4, 1, 0, 0);
    // Restart with an out-of-range select, then switch to program 1 while loading.
    drv(0, 1, 2'd3, 0, 0, 0); ex("done_st",   0, 0,   0, 1, 7, 4, 1, 0, 0);
    drv(0, 1, 2'd3, 0, 0, 0); ex("load_sel3", 1, 0,   0, 0, 0, 0, 0, 0, 0);
    drv(0, 0, 2'd1, 0, 0, 0); ex("load_sel1", 1, 128, 0, 0, 0, 0, 0, 0, 0);
    drv(0, 0, 2'd1, 0, 0, 0); ex("run2",      0, 0,   1, 0, 0, 0, 0, 0, 0);
    drv(0, 0, 2'd1, 0, 0, 0); ex("run2_c1",   0, 0,   1, 0, 1, 1, 0, 0, 0);
    drv(0, 0, 2'd1, 0, 0, 0); ex("run2_c2",   0, 0,   1, 0, 2, 2, 0, 0, 0);
    // Abort in RUN cycle 4 together with a halt: Start must win.
    drv(0, 1, 2'd1, 1, 0, 1); ex("abort_cyc", 0, 0,   1, 0, 3, 3, 0, 0, 0);
    drv(0, 0, 2'd1, 0, 0, 0); ex("abort_ld",  1, 128, 0, 0, 0, 0, 0, 0, 0);
    drv(0, 0, 2'd1, 0, 0, 0); ex("rerun",     0, 0,   1, 0, 0, 0, 0, 0, 0);
    // Twenty plain cycles: saturation, or watchdog when enabled.
    for (int k = 1; k <= 20; k++) begin
      drv(0, 0, 2'd1, 0, 0, 0);
`ifdef PROG_RUN_WATCHDOG_EN
      if (k == 10 || k == 14 || k == 16 || k == 20) ex("wdog", 0, 0, 0, 1, 10, 10, 0, 0, 1);
`else
      if (k == 10) ex("no_wdog", 0, 0, 1, 0, 10, 10, 0, 0, 0);
      if (k == 14) ex("sat_pre", 0, 0, 1, 0, 14, 14, 0, 0, 0);
      if (k == 16 || k == 20) ex("sat_hold", 0, 0, 1, 0, 15, 15, 0, 1, 0);
`endif
    end
    drv(0, 1, 2'd1, 0, 0, 0);
    drv(0, 0, 2'd1, 0, 0, 0); ex("ovf_clear", 1, 128, 0, 0, 0, 0, 0, 0, 0);
    // Reset in the middle of a run.
    drv(0, 0, 2'd1, 0, 0, 0); ex("run3",      0, 0,   1, 0, 0, 0, 0, 0, 0);
    drv(0, 0, 2'd1, 0, 0, 0); ex("run3_c1",   0, 0,   1, 0, 1, 1, 0, 0, 0);
    drv(1, 0, 2'd1, 0, 0, 0); ex("pre_reset", 0, 0,   1, 0, 2, 2, 0, 0, 0);
    drv(0, 0, 2'd1, 0, 0, 0); ex("reset_mid", 0, 0,   0, 0, 0, 0, 0, 0, 0);
    drv(0, 0, 2'd1, 0, 0, 0); ex("idle_hold", 0, 0,   0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge Clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
